// File: rtl/tta_arb_pkg.sv
// Shared types and constants for the TTA instruction/data memory arbiter.
package tta_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GRANT_I,
        GRANT_D
    } arb_state_e;

    typedef enum logic {
        GRANT_INSTR,
        GRANT_DATA
    } grant_e;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/arb_watchdog.sv
// Saturating cycle counter that flags a granted transaction the memory has not acknowledged
// within TIMEOUT_CYCLES cycles. TIMEOUT_CYCLES = 0 never expires.
module arb_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CntW-1:0] Limit = (TIMEOUT_CYCLES > 0) ? CntW'(TIMEOUT_CYCLES - 1) : '0;

    logic [CntW-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (TIMEOUT_CYCLES != 0) && (cnt_q == Limit);

endmodule

// File: rtl/tta_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between the TTA fetch and data buses, with a
// watchdog that completes unacknowledged transactions with an error.
module tta_mem_arbiter
    import tta_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter logic [31:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] instr_addr_i,
    input  logic        instr_valid_i,
    output logic        instr_ready_o,
    output logic [31:0] instr_data_read_o,
    input  logic [31:0] data_addr_i,
    input  logic        data_valid_i,
    input  logic [31:0] data_data_write_i,
    input  logic [3:0]  data_wstrb_i,
    output logic        data_ready_o,
    output logic [31:0] data_data_read_o,
    output logic [31:0] mem_addr_o,
    output logic        mem_valid_o,
    input  logic        mem_ready_i,
    input  logic [31:0] mem_data_read_i,
    output logic [31:0] mem_data_write_o,
    output logic [3:0]  mem_wstrb_o,
    output logic        err_o
);

    arb_state_e  state_d, state_q;
    grant_e      last_grant_d, last_grant_q;
    logic [31:0] mem_addr_d, mem_addr_q;
    logic [31:0] mem_wdata_d, mem_wdata_q;
    logic [3:0]  mem_wstrb_d, mem_wstrb_q;
    logic        mem_valid_d, mem_valid_q;
    logic        in_grant, expired, timeout, done;
    logic [31:0] rdata;

    assign in_grant = (state_q != IDLE);
    // A real acknowledge in the expiry cycle wins over the timeout.
    assign timeout  = in_grant && expired && !mem_ready_i;
    assign done     = in_grant && (mem_ready_i || expired);

    arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (!in_grant),
        .enable_i (in_grant && !mem_ready_i),
        .expired_o(expired)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wstrb_d  = mem_wstrb_q;
        mem_valid_d  = mem_valid_q;
        unique case (state_q)
            IDLE: begin
                mem_valid_d = 1'b0;
                if (instr_valid_i && (!data_valid_i || (last_grant_q == GRANT_DATA))) begin
                    state_d      = GRANT_I;
                    last_grant_d = GRANT_INSTR;
                    mem_addr_d   = instr_addr_i;
                    mem_wdata_d  = '0;
                    mem_wstrb_d  = '0;
                    mem_valid_d  = 1'b1;
                end else if (data_valid_i) begin
                    state_d      = GRANT_D;
                    last_grant_d = GRANT_DATA;
                    mem_addr_d   = data_addr_i;
                    mem_wdata_d  = data_data_write_i;
                    mem_wstrb_d  = data_wstrb_i;
                    mem_valid_d  = 1'b1;
                end
            end
            GRANT_I, GRANT_D: begin
                if (done) begin
                    state_d     = IDLE;
                    mem_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                mem_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_DATA;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wstrb_q  <= '0;
            mem_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wstrb_q  <= mem_wstrb_d;
            mem_valid_q  <= mem_valid_d;
        end
    end

    assign rdata             = timeout ? ERR_DATA : mem_data_read_i;
    assign instr_ready_o     = (state_q == GRANT_I) && done;
    assign data_ready_o      = (state_q == GRANT_D) && done;
    assign instr_data_read_o = instr_ready_o ? rdata : '0;
    assign data_data_read_o  = data_ready_o ? rdata : '0;
    assign err_o             = timeout;
    assign mem_addr_o        = mem_addr_q;
    assign mem_valid_o       = mem_valid_q;
    assign mem_data_write_o  = mem_wdata_q;
    assign mem_wstrb_o       = mem_wstrb_q;

endmodule

// File: tb/tb_tta_mem_arbiter.sv
// Directed bench for tta_mem_arbiter: the bench plays the memory and checks each granted
// transaction against a queue of expected transactions pushed when requests are raised.
module tb_tta_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr_addr_i = '0;
    logic        instr_valid_i = 1'b0;
    logic        instr_ready_o;
    logic [31:0] instr_data_read_o;
    logic [31:0] data_addr_i = '0;
    logic        data_valid_i = 1'b0;
    logic [31:0] data_data_write_i = '0;
    logic [3:0]  data_wstrb_i = '0;
    logic        data_ready_o;
    logic [31:0] data_data_read_o;
    logic [31:0] mem_addr_o;
    logic        mem_valid_o;
    logic        mem_ready_i = 1'b0;
    logic [31:0] mem_data_read_i = '0;
    logic [31:0] mem_data_write_o;
    logic [3:0]  mem_wstrb_o;
    logic        err_o;

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit          is_instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
        int          lat;
        bit          timeout;
    } txn_t;

    txn_t sb[$];

    tta_mem_arbiter #(
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .instr_addr_i     (instr_addr_i),
        .instr_valid_i    (instr_valid_i),
        .instr_ready_o    (instr_ready_o),
        .instr_data_read_o(instr_data_read_o),
        .data_addr_i      (data_addr_i),
        .data_valid_i     (data_valid_i),
        .data_data_write_i(data_data_write_i),
        .data_wstrb_i     (data_wstrb_i),
        .data_ready_o     (data_ready_o),
        .data_data_read_o (data_data_read_o),
        .mem_addr_o       (mem_addr_o),
        .mem_valid_o      (mem_valid_o),
        .mem_ready_i      (mem_ready_i),
        .mem_data_read_i  (mem_data_read_i),
        .mem_data_write_o (mem_data_write_o),
        .mem_wstrb_o      (mem_wstrb_o),
        .err_o            (err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input bit is_instr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input logic [31:0] rdata, input int lat,
                        input bit timeout);
        txn_t t;
        t.is_instr = is_instr;
        t.addr     = addr;
        t.wdata    = wdata;
        t.wstrb    = wstrb;
        t.rdata    = rdata;
        t.lat      = lat;
        t.timeout  = timeout;
        sb.push_back(t);
    endtask

    // Acts as memory for the next expected transaction; optionally drops valids on completion
    // and scrambles the data-side inputs right after the grant edge.
    task automatic serve(input bit drop_i, input bit drop_d, input bit scramble);
        txn_t        t;
        int          n;
        logic [31:0] exp_rd;
        if (sb.size() == 0) begin
            failures++;
            $error("FAIL sb_underflow observed=empty expected=entry");
            return;
        end
        t = sb.pop_front();
        n = 0;
        while (mem_valid_o !== 1'b1 && n < 16) begin
            tick();
            n++;
        end
        chk("grant_latency", n, 1);
        chk("mem_addr", mem_addr_o, t.addr);
        chk("mem_wstrb", {28'b0, mem_wstrb_o}, {28'b0, t.wstrb});
        if (!t.is_instr) chk("mem_wdata", mem_data_write_o, t.wdata);
        if (scramble) begin
            data_addr_i       = 32'h0000_3333;
            data_data_write_i = 32'h0000_0BAD;
            data_wstrb_i      = 4'hC;
        end
        for (int c = 0; c < t.lat; c++) begin
            mem_ready_i     = 1'b0;
            mem_data_read_i = 32'h5A5A_5A5A;
            #1;
            chk("wait_ready", {29'b0, instr_ready_o, data_ready_o, err_o}, 0);
            chk("wait_rdata", instr_data_read_o | data_data_read_o, 0);
            tick();
            chk("hold_valid", mem_valid_o, 1);
            chk("hold_addr", mem_addr_o, t.addr);
            chk("hold_wstrb", {28'b0, mem_wstrb_o}, {28'b0, t.wstrb});
            if (!t.is_instr) chk("hold_wdata", mem_data_write_o, t.wdata);
        end
        mem_ready_i     = !t.timeout;
        mem_data_read_i = t.rdata;
        #1;
        exp_rd = t.timeout ? 32'hDEAD_BEEF : t.rdata;
        chk("instr_ready", instr_ready_o, t.is_instr);
        chk("data_ready", data_ready_o, !t.is_instr);
        chk("instr_rdata", instr_data_read_o, t.is_instr ? exp_rd : 32'h0);
        chk("data_rdata", data_data_read_o, t.is_instr ? 32'h0 : exp_rd);
        chk("err", err_o, t.timeout);
        if (drop_i) instr_valid_i = 1'b0;
        if (drop_d) data_valid_i = 1'b0;
        tick();
        mem_ready_i = 1'b0;
        #1;
        chk("idle_valid", mem_valid_o, 0);
        chk("idle_ready", {29'b0, instr_ready_o, data_ready_o, err_o}, 0);
    endtask

    initial begin
        #3;
        chk("rst_mem_valid", mem_valid_o, 0);
        chk("rst_mem_addr", mem_addr_o, 0);
        chk("rst_mem_wdata", mem_data_write_o, 0);
        chk("rst_mem_wstrb", {28'b0, mem_wstrb_o}, 0);
        chk("rst_ready", {29'b0, instr_ready_o, data_ready_o, err_o}, 0);
        chk("rst_rdata", instr_data_read_o | data_data_read_o, 0);
        tick();
        rst = 1'b0;
        tick();

        // Fetch only
        push(1'b1, 32'h100, 32'h0, 4'h0, 32'h1234, 1, 1'b0);
        instr_addr_i  = 32'h100;
        instr_valid_i = 1'b1;
        serve(1'b1, 1'b0, 1'b0);

        // Store alone; inputs change after the grant edge
        push(1'b0, 32'h44, 32'hAA55, 4'h3, 32'h0000_0077, 2, 1'b0);
        data_addr_i       = 32'h44;
        data_data_write_i = 32'hAA55;
        data_wstrb_i      = 4'h3;
        data_valid_i      = 1'b1;
        serve(1'b0, 1'b1, 1'b1);

        // Tie held across three grants: instr, data, instr
        instr_addr_i      = 32'h10;
        instr_valid_i     = 1'b1;
        data_addr_i       = 32'h20;
        data_data_write_i = 32'hAA55;
        data_wstrb_i      = 4'hF;
        data_valid_i      = 1'b1;
        push(1'b1, 32'h10, 32'h0, 4'h0, 32'h1111, 0, 1'b0);
        push(1'b0, 32'h20, 32'hAA55, 4'hF, 32'h2222, 2, 1'b0);
        push(1'b1, 32'h10, 32'h0, 4'h0, 32'h3333, 1, 1'b0);
        serve(1'b0, 1'b0, 1'b0);
        serve(1'b0, 1'b0, 1'b0);
        serve(1'b1, 1'b1, 1'b0);

        // Watchdog timeout, then a normal load
        push(1'b1, 32'h200, 32'h0, 4'h0, 32'h7777, 3, 1'b1);
        instr_addr_i  = 32'h200;
        instr_valid_i = 1'b1;
        serve(1'b1, 1'b0, 1'b0);
        push(1'b0, 32'h300, 32'h0, 4'h0, 32'h5555, 0, 1'b0);
        data_addr_i       = 32'h300;
        data_data_write_i = 32'h0;
        data_wstrb_i      = 4'h0;
        data_valid_i      = 1'b1;
        serve(1'b0, 1'b1, 1'b0);

        // Acknowledge in the expiry cycle beats the timeout
        push(1'b0, 32'h304, 32'h0, 4'h0, 32'hCAFE, 3, 1'b0);
        data_addr_i  = 32'h304;
        data_valid_i = 1'b1;
        serve(1'b0, 1'b1, 1'b0);

        // Asynchronous reset mid GRANT_D
        data_addr_i       = 32'h20;
        data_data_write_i = 32'hAA55;
        data_wstrb_i      = 4'hF;
        data_valid_i      = 1'b1;
        tick();
        tick();
        chk("pre_reset_grant", mem_valid_o, 1);
        mem_ready_i     = 1'b1;
        mem_data_read_i = 32'h9999;
        #2;
        rst = 1'b1;
        #1;
        chk("async_mem_valid", mem_valid_o, 0);
        chk("async_mem_addr", mem_addr_o, 0);
        chk("async_mem_wdata", mem_data_write_o, 0);
        chk("async_mem_wstrb", {28'b0, mem_wstrb_o}, 0);
        chk("async_ready", {29'b0, instr_ready_o, data_ready_o, err_o}, 0);
        chk("async_rdata", instr_data_read_o | data_data_read_o, 0);
        mem_ready_i = 1'b0;
        tick();
        chk("held_reset_valid", mem_valid_o, 0);
        rst           = 1'b0;
        instr_addr_i  = 32'h10;
        instr_valid_i = 1'b1;
        push(1'b1, 32'h10, 32'h0, 4'h0, 32'hABCD, 0, 1'b0);
        push(1'b0, 32'h20, 32'hAA55, 4'hF, 32'h4242, 1, 1'b0);
        serve(1'b1, 1'b0, 1'b0);
        serve(1'b0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule
